// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_sched
// Purpose  : N-channel, W-bit registered mux with round-robin arbitration and
//            valid/ready handshakes on every input channel and on the output.
//            Optional feature macro: MUX_RR_FORCE_EN (adds force_en/force_sel).
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef MUX_RR_FORCE_EN
    input  logic                   force_en,
    input  logic [SELW-1:0]        force_sel,
`endif
    output logic [NCH-1:0]         in_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SELW:0]   C_NCH_EXT  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] C_LAST_CH  = SELW'(NCH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SELW-1:0]    ch_q,    ch_d;
    logic [SELW-1:0]    ptr_q,   ptr_d;

    logic [NCH-1:0]     w_elig;
    logic               w_forced;
    logic               w_grant_found;
    logic [SELW-1:0]    w_grant_idx;
    logic               w_load_ok;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // Channel index base+off, wrapped modulo NCH (not modulo 2^SELW).
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input int unsigned     off);
        logic [SELW:0] sum;
        sum = {1'b0, base} + (SELW+1)'(off);
        if (sum >= C_NCH_EXT) begin
            sum = sum - C_NCH_EXT;
        end
        return sum[SELW-1:0];
    endfunction

    // Eligible request mask.
`ifdef MUX_RR_FORCE_EN
    always_comb begin
        w_elig   = in_valid;
        w_forced = 1'b0;
        if (force_en) begin
            w_forced = 1'b1;
            w_elig   = '0;
            for (int k = 0; k < NCH; k++) begin
                if (force_sel == SELW'(k)) begin
                    w_elig[k] = in_valid[k];
                end
            end
        end
    end
`else
    always_comb begin
        w_elig   = in_valid;
        w_forced = 1'b0;
    end
`endif

    // Round-robin scan starting at ptr_q.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_grant_found && w_elig[wrap_add(ptr_q, i)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    assign w_load_ok  = (state_q == EMPTY) || out_ready;
    assign w_in_xfer  = w_grant_found && w_load_ok;
    assign w_out_xfer = (state_q == FULL) && out_ready;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = w_in_xfer && (w_grant_idx == SELW'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (w_in_xfer) begin
            state_d = FULL;
            data_d  = in_data[w_grant_idx*WIDTH +: WIDTH];
            ch_d    = w_grant_idx;
            // Forced transfers leave the round-robin order untouched.
            if (!w_forced) begin
                ptr_d = (w_grant_idx == C_LAST_CH) ? '0 : w_grant_idx + 1'b1;
            end
        end else if (w_out_xfer) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule
`default_nettype wire
